// File: rtl/edulent_out_arbiter.sv
// edulent_out_arbiter
// Round-robin arbiter sharing the 8-bit o_out port between NUM_REQ internal
// requesters. A granted byte is registered onto o_out and held for at least
// HOLD_CYCLES cycles. It is released once the downstream sink is ready.
//
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_req_valid    per-requester "byte pending"
//   i_req_data     requester k byte at [k*DATA_W +: DATA_W]
//   o_req_ready    one-hot accept strobe (IDLE only, combinational)
//   o_out          registered output byte
//   o_out_valid    o_out holds a granted, not yet consumed byte
//   i_out_ready    downstream sink can consume o_out
//   o_grant_id     requester index whose byte is on o_out
//   o_busy         FSM is in SHOW
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no byte on the port; grant the next requester in RR order
// SHOW  | byte presented; wait for hold time, then for i_out_ready
module edulent_out_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int HOLD_CYCLES = 2,
   localparam int ID_W       = $clog2(NUM_REQ),
   localparam int HC_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   output logic [NUM_REQ-1:0]        o_req_ready,
   output logic [DATA_W-1:0]         o_out,
   output logic                      o_out_valid,
   input  logic                      i_out_ready,
   output logic [ID_W-1:0]           o_grant_id,
   output logic                      o_busy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   localparam logic [HC_W-1:0] HC_MAX = HC_W'(HOLD_CYCLES - 1);
   localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

   state_t           state;
   logic [ID_W-1:0]  ptr;
   logic [HC_W-1:0]  hold_cnt;

   logic             win_found;
   logic [ID_W-1:0]  win_id;
   logic [ID_W-1:0]  idx_l;
   int               idx;

   // Search starts just after the last winner, so the last winner has lowest
   // priority next time round.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      idx_l     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx   = (int'(ptr) + i) % NUM_REQ;
         idx_l = ID_W'(idx);
         if (!win_found && i_req_valid[idx_l]) begin
            win_found = 1'b1;
            win_id    = idx_l;
         end
      end
   end

   // Depends only on state, ptr, valids and reset; never on i_out_ready.
   always_comb begin
      o_req_ready = '0;
      if (!i_rst && (state == ST_IDLE) && win_found)
         o_req_ready[win_id] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         ptr         <= PTR_RST;
         hold_cnt    <= '0;
         o_out       <= '0;
         o_out_valid <= 1'b0;
         o_grant_id  <= '0;
         o_busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_found) begin
                  o_out       <= i_req_data[int'(win_id)*DATA_W +: DATA_W];
                  o_grant_id  <= win_id;
                  ptr         <= win_id;
                  hold_cnt    <= '0;
                  o_out_valid <= 1'b1;
                  o_busy      <= 1'b1;
                  state       <= ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (hold_cnt != HC_MAX)
                  hold_cnt <= hold_cnt + 1'b1;
               // Ready before the hold time is met is deliberately ignored.
               if ((hold_cnt == HC_MAX) && i_out_ready) begin
                  o_out_valid <= 1'b0;
                  o_busy      <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
